mult_div_unit: RTL and testbench

//  Iterative multiply/divide unit for the MIPS datapath; successor to the combinational ALU decode.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mult_div_unit_if.sv | 27 ++
 rtl/mdu_iter_core.sv | 47 ++++
 rtl/mult_div_unit.sv | 124 ++++++++++++
 tb/tb_mult_div_unit.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: R-type function codes,
// FSM state encoding, operation class and the iteration counter width.
package mdu_pkg;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    localparam int CNT_W = 6;

    typedef enum logic [1:0] {IDLE, RUN, FIN} mdu_state_t;
    typedef enum logic {OP_MUL, OP_DIV} mdu_op_t;

    // Function codes that start a multi-cycle iteration.
    function automatic logic is_iter_fn(input logic [5:0] f);
        return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
//   start, alu_op, func, a, b : request side (driven by the master)
//   busy, done, hi, lo, result: unit status and HI/LO views (driven by the slave)
interface mult_div_unit_if #(parameter int WIDTH = 32);

    logic             start;
    logic [1:0]       alu_op;
    logic [5:0]       func;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] result;

    modport master (
        output start, alu_op, func, a, b,
        input  busy, done, hi, lo, result
    );

    modport slave (
        input  start, alu_op, func, a, b,
        output busy, done, hi, lo, result
    );

endinterface

// File: rtl/mdu_iter_core.sv
// One iteration step of the unsigned shift-add multiplier / restoring divider.
//   op      : OP_MUL or OP_DIV
//   acc     : upper half (product high part / partial remainder)
//   q       : lower half (multiplier being consumed / dividend shifting into quotient)
//   m       : multiplicand or divisor magnitude
//   acc_nxt, q_nxt : values after this step
module mdu_iter_core
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  mdu_op_t          op,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] q_nxt
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH+1:0] diff;
    logic             unused_bits;

    always_comb begin
        sum  = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
        r_sh = {acc, q[WIDTH-1]};
        diff = {1'b0, r_sh} - {2'b00, m};
        if (op == OP_MUL) begin
            // Add then shift the whole {acc,q} pair right; the carry lands in acc's MSB.
            acc_nxt = sum[WIDTH:1];
            q_nxt   = {sum[0], q[WIDTH-1:1]};
        end else if (diff[WIDTH+1]) begin
            // Trial subtract borrowed: restore, quotient bit 0.
            acc_nxt = r_sh[WIDTH-1:0];
            q_nxt   = {q[WIDTH-2:0], 1'b0};
        end else begin
            acc_nxt = diff[WIDTH-1:0];
            q_nxt   = {q[WIDTH-2:0], 1'b1};
        end
    end

    // When no borrow occurs the difference is below the divisor, so these
    // bits are always zero on the path that is used.
    assign unused_bits = ^{r_sh[WIDTH], diff[WIDTH]};

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : slave side of mult_div_unit_if
//                start/alu_op/func/a/b in; busy/done/hi/lo/result out
//
// state | meaning
// IDLE  | waiting for an accepted mult/multu/div/divu (mthi/mtlo complete here)
// RUN   | one iteration per cycle while the counter runs WIDTH-1 down to 0
// FIN   | sign fix-up; HI/LO written at the end of this cycle
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    mult_div_unit_if.slave bus
);

    mdu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_q, q_q, m_q, hi_q, lo_q;
    logic [WIDTH-1:0] acc_nxt, q_nxt;
    mdu_op_t          op_q;
    logic             sa_q, sb_q, dz_q, done_q;

    logic             acc_op, acc_mt, sgn_op, is_div, sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign acc_op = bus.start && (state_q == IDLE) && bus.alu_op[1] && is_iter_fn(bus.func);
    assign acc_mt = bus.start && (state_q == IDLE) && bus.alu_op[1] &&
                    ((bus.func == FN_MTHI) || (bus.func == FN_MTLO));
    assign sgn_op = (bus.func == FN_MULT) || (bus.func == FN_DIV);
    assign is_div = (bus.func == FN_DIV) || (bus.func == FN_DIVU);
    assign sa     = sgn_op & bus.a[WIDTH-1];
    assign sb     = sgn_op & bus.b[WIDTH-1];
    assign mag_a  = sa ? -bus.a : bus.a;
    assign mag_b  = sb ? -bus.b : bus.b;

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .op      (op_q),
        .acc     (acc_q),
        .q       (q_q),
        .m       (m_q),
        .acc_nxt (acc_nxt),
        .q_nxt   (q_nxt)
    );

    // Remainder follows the dividend's sign; quotient/product follow sign mismatch.
    assign prod_fix = (sa_q ^ sb_q) ? -{acc_q, q_q} : {acc_q, q_q};
    assign quo_fix  = (sa_q ^ sb_q) ? -q_q : q_q;
    assign rem_fix  = sa_q ? -acc_q : acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (acc_op) state_d = RUN;
            RUN:     if (cnt_q == '0) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            q_q    <= '0;
            m_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            op_q   <= OP_MUL;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            dz_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (acc_op) begin
                op_q  <= is_div ? OP_DIV : OP_MUL;
                sa_q  <= sa;
                sb_q  <= sb;
                dz_q  <= (bus.b == '0);
                acc_q <= '0;
                // m holds the multiplicand or divisor; q the multiplier or dividend.
                m_q   <= is_div ? mag_b : mag_a;
                q_q   <= is_div ? mag_a : mag_b;
                cnt_q <= CNT_W'(WIDTH - 1);
            end else if (acc_mt) begin
                if (bus.func == FN_MTHI) hi_q <= bus.a;
                else                     lo_q <= bus.a;
                done_q <= 1'b1;
            end else if (state_q == RUN) begin
                acc_q <= acc_nxt;
                q_q   <= q_nxt;
                if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            end else if (state_q == FIN) begin
                done_q <= 1'b1;
                if (op_q == OP_MUL) begin
                    {hi_q, lo_q} <= prod_fix;
                end else begin
                    // Divide by zero: the remainder path already yields a; force quotient to all ones.
                    hi_q <= rem_fix;
                    lo_q <= dz_q ? '1 : quo_fix;
                end
            end
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_q;
    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;
    assign bus.result = (bus.func == FN_MFHI) ? hi_q :
                        (bus.func == FN_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: returns {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv);
        longint sa, sb, qq, rr;
        logic [63:0] ua, ub, r;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        ua = {32'b0, av};
        ub = {32'b0, bv};
        r  = '0;
        case (f)
            FN_MULT:  r = 64'(sa * sb);
            FN_MULTU: r = ua * ub;
            FN_DIV: begin
                if (bv == 0) r = {av, 32'hFFFF_FFFF};
                else begin
                    qq = sa / sb;
                    rr = sa % sb;
                    r  = {32'(rr), 32'(qq)};
                end
            end
            FN_DIVU: begin
                if (bv == 0) r = {av, 32'hFFFF_FFFF};
                else r = {32'(ua % ub), 32'(ua / ub)};
            end
            default: r = {m_hi, m_lo};
        endcase
        return r;
    endfunction

    task automatic idle_inputs();
        bus.start  = 1'b0;
        bus.alu_op = 2'b10;
        bus.func   = 6'b000000;
        bus.a      = '0;
        bus.b      = '0;
    endtask

    // Issue an iterative op; optionally keep asserting start (divu) for 'spam' cycles.
    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] av,
                          input logic [31:0] bv, input int spam);
        logic [63:0] exp;
        logic [31:0] pre_lo;
        int bc, dc;
        exp    = model(f, av, bv);
        pre_lo = m_lo;
        @(negedge clk);
        bus.start = 1'b1; bus.alu_op = 2'b10; bus.func = f; bus.a = av; bus.b = bv;
        @(posedge clk);
        bc = 0; dc = 0;
        for (int i = 0; i < W + 1; i++) begin
            @(negedge clk);
            if (i < spam) begin
                bus.start = 1'b1; bus.func = FN_DIVU; bus.a = 32'd100; bus.b = 32'd7;
            end else begin
                bus.start = 1'b0; bus.func = FN_MFLO;
            end
            if (bus.busy) bc++;
            if (bus.done) dc++;
            if (i == W / 2 && spam == 0) begin
                #1;
                chk({tag, "_result_hold"}, 64'(bus.result), 64'(pre_lo));
            end
        end
        chk({tag, "_busy_cycles"}, 64'(bc), 64'(W + 1));
        chk({tag, "_done_early"}, 64'(dc), 64'd0);
        @(negedge clk);
        chk({tag, "_done"}, 64'(bus.done), 64'd1);
        chk({tag, "_busy_off"}, 64'(bus.busy), 64'd0);
        chk({tag, "_hi"}, 64'(bus.hi), 64'(exp[63:32]));
        chk({tag, "_lo"}, 64'(bus.lo), 64'(exp[31:0]));
        bus.func = FN_MFHI;
        #1;
        chk({tag, "_mfhi"}, 64'(bus.result), 64'(exp[63:32]));
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    task automatic run_mt(input string tag, input logic [5:0] f, input logic [31:0] av);
        @(negedge clk);
        bus.start = 1'b1; bus.alu_op = 2'b10; bus.func = f; bus.a = av;
        @(posedge clk);
        if (f == FN_MTHI) m_hi = av; else m_lo = av;
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, "_done"}, 64'(bus.done), 64'd1);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_hi"}, 64'(bus.hi), 64'(m_hi));
        chk({tag, "_lo"}, 64'(bus.lo), 64'(m_lo));
        bus.func = (f == FN_MTHI) ? FN_MFHI : FN_MFLO;
        #1;
        chk({tag, "_result"}, 64'(bus.result), 64'(av));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    task automatic run_ignored(input string tag, input logic [1:0] op, input logic [5:0] f);
        int bc, dc;
        @(negedge clk);
        bus.start = 1'b1; bus.alu_op = op; bus.func = f;
        bus.a = $urandom; bus.b = $urandom;
        bc = 0; dc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.busy) bc++;
            if (bus.done) dc++;
        end
        bus.alu_op = 2'b10;
        chk({tag, "_busy"}, 64'(bc), 64'd0);
        chk({tag, "_done"}, 64'(dc), 64'd0);
        chk({tag, "_hilo"}, {bus.hi, bus.lo}, {m_hi, m_lo});
    endtask

    initial begin
        logic [5:0] fns [4];
        int bc, dc;
        logic [31:0] ra, rb;
        fns[0] = FN_MULT; fns[1] = FN_MULTU; fns[2] = FN_DIV; fns[3] = FN_DIVU;

        idle_inputs();
        bus.func = FN_MFHI;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("mult_7_m3", FN_MULT, 32'd7, 32'hFFFF_FFFD, 0);
        run_op("multu", FN_MULTU, 32'hFFFF_FFFF, 32'd2, 0);
        run_op("divu_100_7", FN_DIVU, 32'd100, 32'd7, 0);
        run_op("div_m7_2", FN_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("div_by0", FN_DIV, 32'd5, 32'd0, 0);
        run_op("div_by0_neg", FN_DIV, 32'hFFFF_FF00, 32'd0, 0);
        run_op("div_ovf", FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("mult_busy_starts", FN_MULT, 32'd3, 32'd4, 5);
        run_mt("mtlo", FN_MTLO, 32'h0000_00A5);
        run_mt("mthi", FN_MTHI, $urandom);

        run_ignored("ign_aluop01", 2'b01, FN_MULT);
        run_ignored("ign_aluop00", 2'b00, FN_MTLO);
        run_ignored("ign_func", 2'b10, 6'b100000);
        run_ignored("ign_mfhi", 2'b10, FN_MFHI);

        // Reset in the middle of a multiply.
        @(negedge clk);
        bus.start = 1'b1; bus.alu_op = 2'b10; bus.func = FN_MULT;
        bus.a = $urandom; bus.b = $urandom;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        chk("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        bc = 0; dc = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.busy) bc++;
            if (bus.done) dc++;
        end
        chk("midrst_no_done", 64'(dc), 64'd0);
        chk("midrst_no_busy", 64'(bc), 64'd0);
        run_op("after_rst", FN_MULTU, $urandom, $urandom, 0);

        for (int k = 0; k < 20; k++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = -32'($urandom_range(1, 15));
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            run_op($sformatf("rand%0d", k), fns[$urandom_range(0, 3)], ra, rb, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
